// File: rtl/mult_fu_if.sv
// mult_fu_if: issue-side and CDB-side signals of the multiply unit.
// master = RS/arbiter side, slave = the multiply unit.
interface mult_fu_if #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ROB_TAG_LEN = 5,
  parameter int unsigned FUNC_W      = 4
);
  logic                   start;
  logic [FUNC_W-1:0]      func;
  logic [XLEN-1:0]        v1;
  logic [XLEN-1:0]        v2;
  logic [ROB_TAG_LEN-1:0] dst_tag;
  logic                   fu_ready;
  logic                   cdb_req;
  logic                   cdb_grant;
  logic                   wakeup;
  logic [ROB_TAG_LEN-1:0] wakeup_tag;
  logic [XLEN-1:0]        wakeup_value;

  modport master (
    output start, func, v1, v2, dst_tag, cdb_grant,
    input  fu_ready, cdb_req, wakeup, wakeup_tag, wakeup_value
  );

  modport slave (
    input  start, func, v1, v2, dst_tag, cdb_grant,
    output fu_ready, cdb_req, wakeup, wakeup_tag, wakeup_value
  );
endinterface

// File: rtl/mult_fu.sv
// mult_fu: stall-able RV32M multiply pipeline feeding an in-order CDB output buffer.
// Optional MULT_FU_BYPASS_EN: last stage broadcasts directly when the buffer is empty.
module mult_fu #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ROB_TAG_LEN = 5,
  parameter int unsigned FUNC_W      = 4,
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned OUT_DEPTH   = 2,
  parameter int unsigned OUT_PTR_W   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1
) (
  input  logic     clk,
  input  logic     reset,
  mult_fu_if.slave bus
);
  localparam int unsigned PW    = 2 * XLEN;
  localparam int unsigned K     = PW / NUM_STAGES;
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);

  localparam logic [FUNC_W-1:0] FN_MUL    = FUNC_W'(0);
  localparam logic [FUNC_W-1:0] FN_MULH   = FUNC_W'(1);
  localparam logic [FUNC_W-1:0] FN_MULHSU = FUNC_W'(2);
  localparam logic [FUNC_W-1:0] FN_MULHU  = FUNC_W'(3);

  typedef struct packed {
    logic [PW-1:0]          acc;
    logic [PW-1:0]          mc;
    logic [PW-1:0]          mp;
    logic [FUNC_W-1:0]      func;
    logic [ROB_TAG_LEN-1:0] tag;
  } stage_t;

  typedef struct packed {
    logic [ROB_TAG_LEN-1:0] tag;
    logic [XLEN-1:0]        val;
  } ent_t;

  stage_t                  stage_q [NUM_STAGES];
  stage_t                  stage_d [NUM_STAGES];
  logic [NUM_STAGES-1:0]   vld_q, vld_d, en;
  stage_t                  in_s;
  logic                    blk;
  ent_t                    buf_q [OUT_DEPTH];
  logic [OUT_PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    last_vld, full, has_head, byp_req, byp, pop, push, advance;
  logic [XLEN-1:0]         last_res;

  // One K-bit slice of shift-and-add, accumulator modulo 2^PW.
  function automatic stage_t pp_step(input stage_t s);
    stage_t r;
    r = s;
    for (int k = 0; k < int'(K); k++) begin
      if (s.mp[k]) r.acc = r.acc + (s.mc << k);
    end
    r.mc = s.mc << K;
    r.mp = s.mp >> K;
    return r;
  endfunction

  always_comb begin
    in_s      = '0;
    in_s.func = bus.func;
    in_s.tag  = bus.dst_tag;
    case (bus.func)
      FN_MUL, FN_MULH: begin
        in_s.mc = {{XLEN{bus.v1[XLEN-1]}}, bus.v1};
        in_s.mp = {{XLEN{bus.v2[XLEN-1]}}, bus.v2};
      end
      FN_MULHSU: begin
        in_s.mc = {{XLEN{bus.v1[XLEN-1]}}, bus.v1};
        in_s.mp = {{XLEN{1'b0}}, bus.v2};
      end
      FN_MULHU: begin
        in_s.mc = {{XLEN{1'b0}}, bus.v1};
        in_s.mp = {{XLEN{1'b0}}, bus.v2};
      end
      default: ;
    endcase
  end

  assign last_vld = vld_q[NUM_STAGES-1];
  assign has_head = (cnt_q != '0);
  assign full     = (cnt_q == CNT_W'(OUT_DEPTH));

`ifdef MULT_FU_BYPASS_EN
  assign byp_req = last_vld;
`else
  assign byp_req = 1'b0;
`endif

  assign byp     = byp_req && !has_head && bus.cdb_grant;
  assign pop     = has_head && bus.cdb_grant;
  assign advance = !(last_vld && full && !pop);
  assign push    = last_vld && advance && !byp;

  always_comb begin
    case (stage_q[NUM_STAGES-1].func)
      FN_MUL:                       last_res = stage_q[NUM_STAGES-1].acc[XLEN-1:0];
      FN_MULH, FN_MULHSU, FN_MULHU: last_res = stage_q[NUM_STAGES-1].acc[PW-1:XLEN];
      default:                      last_res = '0;
    endcase
  end

  // A stage moves when the stage ahead is empty or moving, so bubbles compact under a stall.
  always_comb begin
    en  = '0;
    blk = !advance;
    for (int s = int'(NUM_STAGES) - 1; s >= 0; s--) begin
      en[s] = !blk;
      blk   = blk && vld_q[s];
    end
    vld_d   = vld_q;
    stage_d = stage_q;
    if (en[0]) begin
      vld_d[0]   = bus.start && advance;
      stage_d[0] = pp_step(in_s);
    end
    for (int s = 1; s < int'(NUM_STAGES); s++) begin
      if (en[s]) begin
        vld_d[s]   = vld_q[s-1];
        stage_d[s] = pp_step(stage_q[s-1]);
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = (wr_ptr_q == OUT_PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + OUT_PTR_W'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == OUT_PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + OUT_PTR_W'(1);
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int s = 0; s < int'(NUM_STAGES); s++) stage_q[s] <= '0;
      for (int e = 0; e < int'(OUT_DEPTH); e++)  buf_q[e]   <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      for (int s = 0; s < int'(NUM_STAGES); s++) stage_q[s] <= stage_d[s];
      if (push) buf_q[wr_ptr_q] <= '{tag: stage_q[NUM_STAGES-1].tag, val: last_res};
    end
  end

  assign bus.fu_ready = advance;
  assign bus.cdb_req  = has_head || byp_req;
  assign bus.wakeup   = pop || byp;

  always_comb begin
    bus.wakeup_tag   = '0;
    bus.wakeup_value = '0;
    if (has_head) begin
      bus.wakeup_tag   = buf_q[rd_ptr_q].tag;
      bus.wakeup_value = buf_q[rd_ptr_q].val;
    end else if (byp_req) begin
      bus.wakeup_tag   = stage_q[NUM_STAGES-1].tag;
      bus.wakeup_value = last_res;
    end
  end
endmodule
